// File: rtl/traffic_lights_pkg.sv
// Shared types and reset constants for the multi-direction crossing controller.
package traffic_lights_pkg;

  typedef enum logic [2:0] {
    CMD_ON         = 3'd0,
    CMD_OFF        = 3'd1,
    CMD_UNREG      = 3'd2,
    CMD_SET_GREEN  = 3'd3,
    CMD_SET_YELLOW = 3'd4,
    CMD_SET_CLEAR  = 3'd5,
    CMD_RSVD6      = 3'd6,
    CMD_RSVD7      = 3'd7
  } cmd_type_t;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_UNREG   = 3'd1,
    ST_CLEAR   = 3'd2,
    ST_RED_YEL = 3'd3,
    ST_GREEN   = 3'd4,
    ST_GBLINK  = 3'd5,
    ST_YELLOW  = 3'd6
  } xing_state_t;

  localparam int DEF_GREEN_MS  = 10000;
  localparam int DEF_YELLOW_MS = 3000;
  localparam int DEF_CLEAR_MS  = 1000;

endpackage

// File: rtl/tl_ms_timer.sv
// Millisecond timer: prescaler plus 16-bit ms counter, pulses done_o when len_ms_i ms have elapsed.
module tl_ms_timer #(
  parameter int CLK_PER_MS = 2
) (
  input  logic        clk_i,
  input  logic        srst_n_i,
  input  logic        restart_i,
  input  logic [15:0] len_ms_i,
  output logic        done_o
);

  localparam int PRE_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_MS - 1);

  logic [PRE_W-1:0] pre_r;
  logic [15:0]      ms_r;
  logic             ms_tick_s;

  assign ms_tick_s = (pre_r == PRE_LAST);
  assign done_o    = ms_tick_s && (ms_r == (len_ms_i - 16'd1));

  // Counters clear on done as well, so the timer free-runs with an exact period.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i || restart_i || done_o) begin
      pre_r <= '0;
      ms_r  <= 16'd0;
    end else if (ms_tick_s) begin
      pre_r <= '0;
      ms_r  <= ms_r + 16'd1;
    end else begin
      pre_r <= pre_r + PRE_W'(1);
    end
  end

endmodule

// File: rtl/traffic_lights_xing.sv
// Multi-direction crossing controller: rotates green through NUM_DIRS heads with all-red gaps,
// plus OFF and unregulated (blinking yellow) modes driven by a 3-bit command interface.
module traffic_lights_xing #(
  parameter int NUM_DIRS              = 3,
  parameter int CLK_PER_MS            = 2,
  parameter int BLINK_HALF_PERIOD_MS  = 1000,
  parameter int BLINK_GREEN_TIME_TICK = 3,
  parameter int RED_YELLOW_MS         = 2000,
  parameter int DEF_GREEN_MS          = traffic_lights_pkg::DEF_GREEN_MS,
  parameter int DEF_YELLOW_MS         = traffic_lights_pkg::DEF_YELLOW_MS,
  parameter int DEF_CLEAR_MS          = traffic_lights_pkg::DEF_CLEAR_MS
) (
  input  logic                        clk_i,
  input  logic                        srst_n_i,
  input  logic [2:0]                  cmd_type_i,
  input  logic                        cmd_valid_i,
  input  logic [15:0]                 cmd_data_i,
  input  logic [$clog2(NUM_DIRS)-1:0] cmd_dir_i,
  output logic [NUM_DIRS-1:0]         red_o,
  output logic [NUM_DIRS-1:0]         yellow_o,
  output logic [NUM_DIRS-1:0]         green_o
);
  import traffic_lights_pkg::*;

  localparam int DIR_W = $clog2(NUM_DIRS);
  localparam logic [DIR_W-1:0] LAST_DIR  = DIR_W'(NUM_DIRS - 1);
  localparam logic [DIR_W:0]   DIR_LIMIT = (DIR_W + 1)'(NUM_DIRS);
  localparam logic [15:0] RY_MS     = 16'(RED_YELLOW_MS);
  localparam logic [15:0] BLINK_MS  = 16'(BLINK_HALF_PERIOD_MS);
  localparam logic [15:0] GBLINK_MS = 16'(BLINK_HALF_PERIOD_MS * 2 * BLINK_GREEN_TIME_TICK);

  xing_state_t         state_r, state_s;
  cmd_type_t           cmd_s;
  logic [DIR_W-1:0]    dir_r, dir_s;
  logic                blink_on_r;
  logic [15:0]         green_ms_r [NUM_DIRS];
  logic [15:0]         yellow_ms_r, clear_ms_r, phase_len_s;
  logic                phase_start_s, phase_done_s, blink_done_s;
  logic [NUM_DIRS-1:0] dir_mask_s, red_s, yellow_s, green_s;

  assign cmd_s      = cmd_type_t'(cmd_type_i);
  assign dir_mask_s = {{(NUM_DIRS-1){1'b0}}, 1'b1} << dir_r;

  tl_ms_timer #(.CLK_PER_MS(CLK_PER_MS)) u_phase_timer (
    .clk_i(clk_i), .srst_n_i(srst_n_i), .restart_i(phase_start_s),
    .len_ms_i(phase_len_s), .done_o(phase_done_s)
  );

  tl_ms_timer #(.CLK_PER_MS(CLK_PER_MS)) u_blink_timer (
    .clk_i(clk_i), .srst_n_i(srst_n_i), .restart_i(phase_start_s),
    .len_ms_i(BLINK_MS), .done_o(blink_done_s)
  );

  // Length of the current regulated phase.
  always_comb begin
    phase_len_s = clear_ms_r;
    case (state_r)
      ST_CLEAR:   phase_len_s = clear_ms_r;
      ST_RED_YEL: phase_len_s = RY_MS;
      ST_GREEN:   phase_len_s = green_ms_r[dir_r];
      ST_GBLINK:  phase_len_s = GBLINK_MS;
      ST_YELLOW:  phase_len_s = yellow_ms_r;
      default:    phase_len_s = clear_ms_r;
    endcase
  end

  // Next state: commands take priority over phase progression.
  always_comb begin
    state_s       = state_r;
    dir_s         = dir_r;
    phase_start_s = 1'b0;
    if (cmd_valid_i && cmd_s == CMD_OFF) begin
      state_s       = ST_OFF;
      phase_start_s = 1'b1;
    end else if (cmd_valid_i && cmd_s == CMD_UNREG) begin
      state_s       = ST_UNREG;
      phase_start_s = 1'b1;
    end else if (cmd_valid_i && cmd_s == CMD_ON && (state_r == ST_OFF || state_r == ST_UNREG)) begin
      state_s       = ST_CLEAR;
      dir_s         = '0;
      phase_start_s = 1'b1;
    end else if (phase_done_s) begin
      case (state_r)
        ST_CLEAR:   begin state_s = ST_RED_YEL; phase_start_s = 1'b1; end
        ST_RED_YEL: begin state_s = ST_GREEN;   phase_start_s = 1'b1; end
        ST_GREEN:   begin state_s = ST_GBLINK;  phase_start_s = 1'b1; end
        ST_GBLINK:  begin state_s = ST_YELLOW;  phase_start_s = 1'b1; end
        ST_YELLOW: begin
          state_s       = ST_CLEAR;
          dir_s         = (dir_r == LAST_DIR) ? '0 : dir_r + DIR_W'(1);
          phase_start_s = 1'b1;
        end
        default:    state_s = state_r;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Lamp pattern for the current state; non-active heads stay red while regulated.
  always_comb begin
    red_s    = '0;
    yellow_s = '0;
    green_s  = '0;
    case (state_r)
      ST_OFF:     red_s = '0;
      ST_UNREG:   yellow_s = {NUM_DIRS{blink_on_r}};
      ST_CLEAR:   red_s = '1;
      ST_RED_YEL: begin red_s = '1; yellow_s = dir_mask_s; end
      ST_GREEN:   begin red_s = ~dir_mask_s; green_s = dir_mask_s; end
      ST_GBLINK:  begin red_s = ~dir_mask_s; green_s = blink_on_r ? dir_mask_s : '0; end
      ST_YELLOW:  begin red_s = ~dir_mask_s; yellow_s = dir_mask_s; end
      default:    red_s = '1;
    endcase
  end

  // State, direction and blink phase registers.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_r    <= ST_CLEAR;
      dir_r      <= '0;
      blink_on_r <= 1'b0;
    end else begin
      state_r <= state_s;
      dir_r   <= dir_s;
      if (phase_start_s) begin
        blink_on_r <= (state_s == ST_UNREG);
      end else if (blink_done_s) begin
        blink_on_r <= ~blink_on_r;
      end
    end
  end

  // Time registers; SET commands only land while unregulated and with a nonzero value.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      for (int i = 0; i < NUM_DIRS; i++) green_ms_r[i] <= 16'(DEF_GREEN_MS);
      yellow_ms_r <= 16'(DEF_YELLOW_MS);
      clear_ms_r  <= 16'(DEF_CLEAR_MS);
    end else if (cmd_valid_i && state_r == ST_UNREG && cmd_data_i != 16'd0) begin
      case (cmd_s)
        CMD_SET_GREEN: begin
          if ({1'b0, cmd_dir_i} < DIR_LIMIT) green_ms_r[cmd_dir_i] <= cmd_data_i;
        end
        CMD_SET_YELLOW: yellow_ms_r <= cmd_data_i;
        CMD_SET_CLEAR:  clear_ms_r  <= cmd_data_i;
        default:        clear_ms_r  <= clear_ms_r;
      endcase
    end
  end

  // Registered lamp outputs.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      red_o    <= '1;
      yellow_o <= '0;
      green_o  <= '0;
    end else begin
      red_o    <= red_s;
      yellow_o <= yellow_s;
      green_o  <= green_s;
    end
  end

endmodule

// File: tb/tb_traffic_lights_xing.sv
// Bench for traffic_lights_xing: vector table, phase-duration sequences and random commands
// checked every cycle against a phase-schedule reference model.
module tb_traffic_lights_xing;
  localparam int ND = 3, CPM = 2, BH = 2, BT = 2, RY_MS = 3, DG = 5, DY = 2, DC = 1;
  localparam int HALF_CYC = BH * CPM;
  localparam int K_CLR = 0, K_RY = 1, K_G = 2, K_GOFF = 3, K_Y = 4, K_UY = 5, K_ZERO = 6;
  localparam int BOUND = 400;

  logic        clk = 1'b0;
  logic        srst_n = 1'b0;
  logic [2:0]  cmd_type = 3'd0;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_data = 16'd0;
  logic [1:0]  cmd_dir = 2'd0;
  logic [2:0]  red, yellow, green;

  always #5 clk = ~clk;

  traffic_lights_xing #(
    .NUM_DIRS(ND), .CLK_PER_MS(CPM), .BLINK_HALF_PERIOD_MS(BH), .BLINK_GREEN_TIME_TICK(BT),
    .RED_YELLOW_MS(RY_MS), .DEF_GREEN_MS(DG), .DEF_YELLOW_MS(DY), .DEF_CLEAR_MS(DC)
  ) dut (
    .clk_i(clk), .srst_n_i(srst_n), .cmd_type_i(cmd_type), .cmd_valid_i(cmd_valid),
    .cmd_data_i(cmd_data), .cmd_dir_i(cmd_dir),
    .red_o(red), .yellow_o(yellow), .green_o(green)
  );

  int total = 0, bad = 0, cyc = 0;

  // Reference model: mode 0 off, 1 unregulated, 2 regulated; phase 0..4 = clear, r+y, g, blink, y.
  int m_mode, m_ph, m_dir, m_el, m_yel, m_clr;
  int m_green [ND];
  logic [8:0] m_exp;

  function automatic logic [8:0] pat(int kind, int d);
    logic [2:0] mk;
    mk = 3'(1 << d);
    case (kind)
      K_CLR:   return {3'b111, 3'b000, 3'b000};
      K_RY:    return {3'b111, mk, 3'b000};
      K_G:     return {~mk, 3'b000, mk};
      K_GOFF:  return {~mk, 3'b000, 3'b000};
      K_Y:     return {~mk, mk, 3'b000};
      K_UY:    return {3'b000, 3'b111, 3'b000};
      default: return 9'd0;
    endcase
  endfunction

  function automatic logic [8:0] lamps();
    return {red, yellow, green};
  endfunction

  function automatic int ph_len();
    case (m_ph)
      0:       return m_clr * CPM;
      1:       return RY_MS * CPM;
      2:       return m_green[m_dir] * CPM;
      3:       return 2 * BT * BH * CPM;
      default: return m_yel * CPM;
    endcase
  endfunction

  function automatic logic [8:0] model_lamps();
    if (m_mode == 0) return 9'd0;
    if (m_mode == 1) return ((m_el / HALF_CYC) % 2 == 0) ? pat(K_UY, 0) : 9'd0;
    case (m_ph)
      0:       return pat(K_CLR, 0);
      1:       return pat(K_RY, m_dir);
      2:       return pat(K_G, m_dir);
      3:       return ((m_el / HALF_CYC) % 2 == 1) ? pat(K_G, m_dir) : pat(K_GOFF, m_dir);
      default: return pat(K_Y, m_dir);
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 2; m_ph = 0; m_dir = 0; m_el = 0; m_yel = DY; m_clr = DC;
    for (int i = 0; i < ND; i++) m_green[i] = DG;
  endtask

  task automatic model_step(input logic rst, input logic valid, input logic [2:0] ty,
                            input logic [15:0] data, input logic [1:0] d);
    if (!rst) begin
      m_exp = pat(K_CLR, 0);
      model_reset();
      return;
    end
    m_exp = model_lamps();
    if (valid && ty == 3'd1) begin
      m_mode = 0; m_el = 0;
    end else if (valid && ty == 3'd2) begin
      m_mode = 1; m_el = 0;
    end else if (valid && ty == 3'd0 && m_mode != 2) begin
      m_mode = 2; m_ph = 0; m_dir = 0; m_el = 0;
    end else begin
      if (valid && m_mode == 1 && data != 16'd0) begin
        if (ty == 3'd3 && int'(d) < ND) m_green[d] = int'(data);
        else if (ty == 3'd4) m_yel = int'(data);
        else if (ty == 3'd5) m_clr = int'(data);
      end
      m_el++;
      if (m_mode == 2 && m_el == ph_len()) begin
        m_el = 0;
        if (m_ph == 4) begin
          m_ph = 0;
          m_dir = (m_dir + 1) % ND;
        end else begin
          m_ph++;
        end
      end
    end
  endtask

  task automatic check_pat(input string nm, input logic [8:0] act, input logic [8:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s (cycle %0d): got rgy=%b want %b", nm, cyc, act, expv);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d cycles want %0d", nm, act, expv);
    end
  endtask

  task automatic cycle(input logic rst, input logic valid, input logic [2:0] ty,
                       input logic [15:0] data, input logic [1:0] d);
    srst_n = rst; cmd_valid = valid; cmd_type = ty; cmd_data = data; cmd_dir = d;
    @(posedge clk);
    model_step(rst, valid, ty, data, d);
    #1;
    cyc++;
    cmd_valid = 1'b0;
    srst_n = 1'b1;
    check_pat("model", lamps(), m_exp);
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 3'd0, 16'd0, 2'd0);
  endtask

  task automatic cmd(input logic [2:0] ty, input logic [15:0] data, input logic [1:0] d);
    cycle(1'b1, 1'b1, ty, data, d);
  endtask

  task automatic wait_pat(input string nm, input logic [8:0] p);
    int w;
    w = 0;
    while (lamps() != p && w < BOUND) begin
      idle();
      w++;
    end
    total++;
    if (w >= BOUND) begin
      bad++;
      $display("FAIL %s: pattern %b not seen within %0d cycles", nm, p, BOUND);
    end
  endtask

  task automatic run_len(input string nm, input logic [8:0] p, input int expv);
    int n;
    n = 0;
    wait_pat(nm, p);
    while (lamps() == p && n < BOUND) begin
      idle();
      n++;
    end
    check_int(nm, n, expv);
  endtask

  typedef struct {
    logic        rst;
    logic        valid;
    logic [2:0]  ty;
    logic [15:0] data;
    logic [1:0]  d;
    logic [8:0]  expv;
  } vec_t;

  vec_t tbl [13];

  initial begin
    model_reset();
    tbl[0]  = '{1'b0, 1'b0, 3'd0, 16'd0, 2'd0, 9'b111_000_000};
    tbl[1]  = '{1'b1, 1'b0, 3'd0, 16'd0, 2'd0, 9'b111_000_000};
    tbl[2]  = '{1'b1, 1'b0, 3'd0, 16'd0, 2'd0, 9'b111_000_000};
    tbl[3]  = '{1'b1, 1'b0, 3'd0, 16'd0, 2'd0, 9'b111_001_000};
    tbl[4]  = '{1'b1, 1'b1, 3'd1, 16'd0, 2'd0, 9'b111_001_000};
    tbl[5]  = '{1'b1, 1'b0, 3'd0, 16'd0, 2'd0, 9'b000_000_000};
    tbl[6]  = '{1'b1, 1'b1, 3'd2, 16'd0, 2'd0, 9'b000_000_000};
    tbl[7]  = '{1'b1, 1'b0, 3'd0, 16'd0, 2'd0, 9'b000_111_000};
    tbl[8]  = '{1'b1, 1'b1, 3'd6, 16'd9, 2'd1, 9'b000_111_000};
    tbl[9]  = '{1'b1, 1'b1, 3'd0, 16'd0, 2'd0, 9'b000_111_000};
    tbl[10] = '{1'b1, 1'b0, 3'd0, 16'd0, 2'd0, 9'b111_000_000};
    tbl[11] = '{1'b1, 1'b0, 3'd0, 16'd0, 2'd0, 9'b111_000_000};
    tbl[12] = '{1'b1, 1'b0, 3'd0, 16'd0, 2'd0, 9'b111_001_000};
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].rst, tbl[i].valid, tbl[i].ty, tbl[i].data, tbl[i].d);
      check_pat($sformatf("vec%0d", i), lamps(), tbl[i].expv);
    end

    // Full rotation from reset with default times.
    cycle(1'b0, 1'b0, 3'd0, 16'd0, 2'd0);
    run_len("t1_ry0", pat(K_RY, 0), 6);
    run_len("t1_g0", pat(K_G, 0), 10);
    run_len("t1_boff0a", pat(K_GOFF, 0), 4);
    run_len("t1_bon0a", pat(K_G, 0), 4);
    run_len("t1_boff0b", pat(K_GOFF, 0), 4);
    run_len("t1_bon0b", pat(K_G, 0), 4);
    run_len("t1_y0", pat(K_Y, 0), 4);
    run_len("t1_clr", pat(K_CLR, 0), 2);
    run_len("t1_ry1", pat(K_RY, 1), 6);
    run_len("t1_g1", pat(K_G, 1), 10);
    run_len("t1_y1", pat(K_Y, 1), 4);
    run_len("t1_ry2", pat(K_RY, 2), 6);
    run_len("t1_y2", pat(K_Y, 2), 4);
    run_len("t1_ry0_again", pat(K_RY, 0), 6);

    // Per-direction green time.
    cmd(3'd2, 16'd0, 2'd0);
    cmd(3'd3, 16'd8, 2'd1);
    cmd(3'd0, 16'd0, 2'd0);
    run_len("t2_g0", pat(K_G, 0), 10);
    run_len("t2_g1", pat(K_G, 1), 16);
    run_len("t2_g2", pat(K_G, 2), 10);

    // Ignored SET commands.
    wait_pat("t3_wait_g0", pat(K_G, 0));
    cmd(3'd3, 16'd2, 2'd0);
    run_len("t3_g0_rest", pat(K_G, 0), 9);
    cmd(3'd2, 16'd0, 2'd0);
    cmd(3'd4, 16'd0, 2'd0);
    cmd(3'd3, 16'd1, 2'd3);
    cmd(3'd0, 16'd0, 2'd0);
    run_len("t3_g0", pat(K_G, 0), 10);
    run_len("t3_y0", pat(K_Y, 0), 4);
    run_len("t3_g1", pat(K_G, 1), 16);
    run_len("t3_y1", pat(K_Y, 1), 4);

    // OFF mid-blink, then ON restarts at dir0.
    wait_pat("t4_wait_blink", pat(K_GOFF, 2));
    idle();
    cmd(3'd1, 16'd0, 2'd0);
    idle();
    check_pat("t4_off", lamps(), 9'd0);
    cmd(3'd0, 16'd0, 2'd0);
    idle(); idle(); idle();
    check_pat("t4_dir0", lamps(), pat(K_RY, 0));

    // Unregulated blinking, then ON.
    cmd(3'd2, 16'd0, 2'd0);
    run_len("t5_on_a", pat(K_UY, 0), 4);
    run_len("t5_off_a", 9'd0, 4);
    run_len("t5_on_b", pat(K_UY, 0), 4);
    cmd(3'd0, 16'd0, 2'd0);
    idle();
    check_pat("t5_clear", lamps(), pat(K_CLR, 0));

    // Reset with OFF mid-yellow of dir2; SET values revert.
    cmd(3'd2, 16'd0, 2'd0);
    cmd(3'd3, 16'd3, 2'd2);
    cmd(3'd4, 16'd3, 2'd0);
    cmd(3'd0, 16'd0, 2'd0);
    wait_pat("t6_wait_y2", pat(K_Y, 2));
    idle();
    cycle(1'b0, 1'b1, 3'd1, 16'd0, 2'd0);
    check_pat("t6_rst", lamps(), pat(K_CLR, 0));
    idle();
    check_pat("t6_not_off", lamps(), pat(K_CLR, 0));
    run_len("t6_ry0", pat(K_RY, 0), 6);
    run_len("t6_g0", pat(K_G, 0), 10);
    run_len("t6_y0", pat(K_Y, 0), 4);
    run_len("t6_g1", pat(K_G, 1), 10);
    run_len("t6_g2", pat(K_G, 2), 10);
    run_len("t6_y2", pat(K_Y, 2), 4);

    // Random commands against the model.
    for (int i = 0; i < 3000; i++) begin
      logic r, v;
      r = ($urandom_range(399, 0) != 0);
      v = ($urandom_range(11, 0) == 0);
      cycle(r, v, 3'($urandom_range(7, 0)), 16'($urandom_range(4, 0)), 2'($urandom_range(3, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
